// File: rtl/req_resp_delay_pipe.sv
// Request/response stimulus pipe: issues a tagged `a` one cycle after an
// accepted request and the matching `b` exactly LATENCY cycles later.
module req_resp_delay_pipe #(
   parameter int LATENCY = 3,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             flush,
   input  logic             req_in,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_ready,
   output logic             valid,
   output logic             a,
   output logic [TAG_W-1:0] a_tag,
   output logic             b,
   output logic [TAG_W-1:0] b_tag,
   output logic [3:0]       outstanding,
   output logic             busy,
   output logic             err_drop
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [LATENCY:0]            vld;
   logic [LATENCY:0][TAG_W-1:0] tag;
   logic [3:0]                  out_q;
   logic                        accept;
   logic                        drained;

   assign accept  = req_in && req_ready;
   // the entry in the last stage is completing now, so it is not pending
   assign drained = ~|vld[LATENCY-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
               if (enable)       state_nxt = RUN;
               else if (drained) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready   = (state == RUN) && !flush;
      valid       = vld[0];
      a           = vld[0];
      a_tag       = vld[0] ? tag[0] : '0;
      b           = vld[LATENCY];
      b_tag       = vld[LATENCY] ? tag[LATENCY] : '0;
      outstanding = out_q;
      busy        = (state != IDLE) || (out_q != 4'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         tag <= '0;
      end else if (flush) begin
         vld <= '0;
         tag <= '0;
      end else begin
         vld <= {vld[LATENCY-1:0], accept};
         tag <= {tag[LATENCY-1:0], (accept ? req_tag : {TAG_W{1'b0}})};
      end
   end

   // tracks entries in stages 0..LATENCY-1 after each edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        out_q <= 4'd0;
      else if (flush) out_q <= 4'd0;
      else            out_q <= out_q + 4'(accept) - 4'(vld[LATENCY-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       err_drop <= 1'b0;
      else if (req_in && !req_ready) err_drop <= 1'b1;
   end

endmodule

// File: tb/tb_req_resp_delay_pipe.sv
// Scoreboard bench for req_resp_delay_pipe: model queues expected a/b
// events by cycle, a monitor compares every cycle after the edge.
module tb_req_resp_delay_pipe;

   localparam int L  = 3;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          flush = 1'b0;
   logic          req_in = 1'b0;
   logic [TW-1:0] req_tag = '0;
   logic          req_ready, valid, a, b, busy, err_drop;
   logic [TW-1:0] a_tag, b_tag;
   logic [3:0]    outstanding;

   req_resp_delay_pipe #(.LATENCY(L), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .req_in(req_in), .req_tag(req_tag), .req_ready(req_ready),
      .valid(valid), .a(a), .a_tag(a_tag), .b(b), .b_tag(b_tag),
      .outstanding(outstanding), .busy(busy), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      int            cyc;
   } ent_t;

   ent_t qa[$];
   ent_t qb[$];
   int   vh[$];
   int   cyc = 0;
   int   mstate = 0;   // 0 idle, 1 run, 2 drain
   int   last_b = -100;
   bit   merr = 1'b0;
   int   passed = 0;
   int   total = 0;

   task automatic chk(string n, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s at cycle %0d: got %0d expected %0d",
                    n, cyc, act, exp);
   endtask

   function automatic void model_clear();
      qa.delete();
      qb.delete();
      vh.delete();
      last_b = -100;
   endfunction

   always @(posedge rst) begin
      model_clear();
      mstate = 0;
      merr   = 1'b0;
   end

   // reference model: evaluated at every edge from the sampled inputs
   always @(posedge clk) begin
      bit rdy;
      cyc++;
      if (rst) begin
         model_clear();
         mstate = 0;
         merr   = 1'b0;
      end else begin
         rdy = (mstate == 1) && !flush;
         if (req_in && !rdy) merr = 1'b1;
         if (flush) begin
            model_clear();
            mstate = 0;
         end else begin
            if (req_in && rdy) begin
               qa.push_back('{req_tag, cyc});
               qb.push_back('{req_tag, cyc + L});
               last_b = cyc + L;
            end
            case (mstate)
               0: if (enable) mstate = 1;
               1: if (!enable) mstate = 2;
               default: begin
                  if (enable)           mstate = 1;
                  else if (last_b < cyc) mstate = 0;
               end
            endcase
         end
      end
   end

   // monitor
   always @(posedge clk) begin
      bit ea, eb;
      int cnt;
      #1;
      if (rst) begin
         chk("rst_ctl", int'({req_ready, valid, a, b, busy, err_drop}), 0);
         chk("rst_dat", int'({a_tag, b_tag, outstanding}), 0);
      end else begin
         ea = (qa.size() > 0) && (qa[0].cyc == cyc);
         chk("a", int'(a), int'(ea));
         chk("valid", int'(valid), int'(ea));
         chk("a_tag", int'(a_tag), ea ? int'(qa[0].tag) : 0);
         if (ea) void'(qa.pop_front());
         eb = (qb.size() > 0) && (qb[0].cyc == cyc);
         chk("b", int'(b), int'(eb));
         chk("b_tag", int'(b_tag), eb ? int'(qb[0].tag) : 0);
         if (eb) void'(qb.pop_front());
         cnt = 0;
         foreach (qb[i]) if (qb[i].cyc > cyc) cnt++;
         chk("outstanding", int'(outstanding), cnt);
         chk("busy", int'(busy), int'(mstate != 0 || cnt != 0));
         chk("req_ready", int'(req_ready), int'(mstate == 1 && !flush));
         chk("err_drop", int'(err_drop), int'(merr));
         // valid |-> a ##L b, with flush/reset cancelling pending attempts
         if (valid) vh.push_back(cyc);
         if (vh.size() > 0 && vh[0] == cyc - L) begin
            chk("impl_b", int'(b), 1);
            void'(vh.pop_front());
         end
      end
   end

   task automatic step(bit en, bit fl, bit rq, int tg);
      enable  = en;
      flush   = fl;
      req_in  = rq;
      req_tag = TW'(tg);
      @(negedge clk);
   endtask

   task automatic idle(bit en, int n);
      for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 0);
   endtask

   initial begin
      bit en_r;
      @(negedge clk);
      rst = 1'b0;
      // single request
      step(1, 0, 1, 5);
      idle(1, 6);
      // back-to-back
      for (int t = 1; t <= 4; t++) step(1, 0, 1, t);
      idle(1, 6);
      // drain
      step(1, 0, 1, 10);
      step(1, 0, 1, 11);
      idle(0, 8);
      // flush with a colliding request
      step(1, 0, 1, 7);
      step(1, 0, 0, 0);
      step(1, 1, 1, 3);
      idle(1, 5);
      // drop while idle, then sticky through traffic
      idle(0, 6);
      step(0, 0, 1, 9);
      step(1, 0, 0, 0);
      for (int t = 0; t < 5; t++) step(1, 0, 1, t + 2);
      idle(1, 5);
      // async reset with entries in flight
      step(1, 0, 1, 12);
      step(1, 0, 1, 13);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ctl", int'({req_ready, valid, a, b, busy, err_drop}), 0);
      chk("async_rst_out", int'(outstanding), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(0, 6);
      // randomized traffic
      en_r = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(9) == 0) en_r = !en_r;
         step(en_r, ($urandom_range(29) == 0), ($urandom_range(9) < 7),
              int'($urandom_range(15)));
      end
      idle(0, 10);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/req_resp_delay_pipe.md
Name: req_resp_delay_pipe

Overview:
- Stimulus-generation stage that drives the `valid`/`a`/`b` handshake consumed by the overlapped-implication checker (`valid |-> a ##LATENCY b`).
- Accepts request pulses with a tag and issues `a` (qualified by `valid`) one cycle later.
- Issues the matching `b` with the same tag exactly LATENCY cycles after `a`.
- Supports back-to-back requests, graceful drain, synchronous flush and dropped-request reporting.

Parameters:
- LATENCY, 3, cycles from `a` to the matching `b`; legal range 1..15.
- TAG_W, 4, width of the request tag carried from `a` to `b`.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; high requests RUN, low requests drain.
- flush  input  1  synchronous pulse; discards all in-flight entries.
- req_in  input  1  request pulse, sampled on posedge.
- req_tag  input  TAG_W  tag captured with `req_in`.
- req_ready  output  1  high when `req_in` will be accepted this cycle.
- valid  output  1  qualifier: high exactly in cycles where `a` is issued with a guaranteed `b`.
- a  output  1  issue strobe.
- a_tag  output  TAG_W  tag of the issued `a`; 0 when `a`=0.
- b  output  1  completion strobe, LATENCY cycles after its `a`.
- b_tag  output  TAG_W  tag of the completing `b`; 0 when `b`=0.
- outstanding  output  4  count of `a` issued whose `b` has not yet been issued.
- busy  output  1  state != IDLE or outstanding != 0.
- err_drop  output  1  sticky; set when `req_in`=1 while `req_ready`=0.

Behaviour:
- Reset (async, `rst`=1): state=IDLE, pipeline cleared. All outputs are 0: `req_ready`, `valid`, `a`, `a_tag`, `b`, `b_tag`, `outstanding`, `busy`, `err_drop`. Release is synchronous to the next posedge.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `enable`=1.
  - RUN -> DRAIN when `enable`=0.
  - DRAIN -> RUN when `enable`=1.
  - DRAIN -> IDLE when the pipeline is empty (`outstanding`=0 and no `b` pending).
  - Any state -> IDLE on `flush`=1; `flush` has priority over `enable`.
- `req_ready` = (state==RUN) && !`flush`. It is combinational from registered state plus `flush`.
- Accept: `req_in`=1 && `req_ready`=1 at posedge N.
  - Entry {1, `req_tag`} enters stage 0.
  - `a`=`valid`=1 and `a_tag`=`req_tag` during cycle N..N+1, i.e. sampled at posedge N+1.
- Pipeline: LATENCY+1 registered stages (stage 0..LATENCY), shifting one stage per clock.
  - `a`/`a_tag` = stage 0.
  - `b`/`b_tag` = stage LATENCY.
  - Consequence: `b` is sampled high exactly LATENCY posedges after its `a`.
- `valid` == `a` at all times. `valid` is never high without `a` and the guaranteed `b`.
- Back-to-back: `req_in` may be high every cycle in RUN. Each accepted request produces a distinct `a` and `b`, in order, with no bubbles or merging.
- `outstanding`: +1 on a cycle with `a`=1, -1 on a cycle with `b`=1; both in the same cycle leaves it unchanged. Maximum value = LATENCY.
- Drain: no new accepts. In-flight entries continue to shift and still produce `b` on schedule.
- Flush at posedge N:
  - All stages cleared at N, so `a`, `b` and `outstanding` are 0 from N+1.
  - A `req_in` in the same cycle is not accepted and sets `err_drop`.
  - Pending `b`s are never issued.
- Drop: `req_in`=1 with `req_ready`=0 sets `err_drop`. It stays set until `rst`; there is no other clear.
- Reset mid-operation: all in-flight entries are lost immediately (asynchronous); no `b` appears after reset release.
- `a_tag`/`b_tag` are forced to 0 when the corresponding strobe is 0.

Test Plan (LATENCY=3, TAG_W=4, 10 ns clock, posedges at 5, 15, 25, …):
- Single request: `enable`=1, `req_in`=1 with tag 5 sampled at 15 -> `valid`=`a`=1 with `a_tag`=5 sampled at 25; `b`=1 with `b_tag`=5 sampled at 55 only; `outstanding` = 1, 1, 1 then 0 at 55.
- Back-to-back: tags 1, 2, 3, 4 sampled at 15, 25, 35, 45 -> `a` sampled at 25–55; `b` sampled at 55–85 with `b_tag`=1, 2, 3, 4; `outstanding` peaks at 3.
- Drain: 2 requests at 15, 25, then `enable`=0 at 35 -> `req_ready`=0 from 35; both `b` sampled at 55 and 65; state IDLE and `busy`=0 after 65.
- Flush: request at 15, `flush` pulse sampled at 35 -> `a` sampled at 25; no `b` at 55; `outstanding`=0 from 45.
- Drop: `req_in`=1 with `enable`=0 -> no `a`; `err_drop`=1 sticky across the following RUN traffic until `rst`.
- Async reset: assert `rst` at 40 ns with 2 entries in flight -> all outputs 0 immediately; no `b` after release.
- Run the checker `valid |-> a ##3 b` throughout all scenarios -> zero failures.
